// File: rtl/uart_rx_fifo_ctrl.sv
// Receive FIFO between the UART receiver and the LPC register decoder: pop handshake, sticky overrun, threshold irq.
// Optional character-timeout interrupt enabled by defining UART_RX_TIMEOUT_EN.
module uart_rx_fifo_ctrl #(
   parameter int DEPTH          = 16,
   parameter int AW             = $clog2(DEPTH),
   parameter int TRIG_LEVEL     = 8,
   parameter int TIMEOUT_CYCLES = 11440
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [7:0]    rx_data,
   input  logic          rx_valid,
   input  logic          rd_en,
   input  logic          flush,
   input  logic          lsr_rd,
   output logic [7:0]    rd_data,
   output logic          data_ready,
   output logic [AW:0]   level,
   output logic          overrun,
   output logic          irq
);

   localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
   localparam logic [AW:0] TRIG_L  = (AW+1)'(TRIG_LEVEL);
   localparam logic [AW:0] ZERO_L  = (AW+1)'(0);
   localparam logic [AW:0] ONE_L   = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE_L = AW'(1);

   logic [7:0]    mem_r [DEPTH];
   logic [AW-1:0] wp_r;
   logic [AW-1:0] rp_r;
   logic [AW:0]   level_r;
   logic [7:0]    rd_data_r;
   logic          overrun_r;
   logic          push_s;
   logic          pop_s;
   logic          drop_s;
   logic          timeout_pend_s;

   // Decode accepted push/pop and dropped bytes; flush discards both.
   always_comb begin
      push_s = 1'b0;
      pop_s  = 1'b0;
      drop_s = 1'b0;
      if (flush) begin
         push_s = 1'b0;
         pop_s  = 1'b0;
         drop_s = 1'b0;
      end else begin
         pop_s = rd_en && (level_r != ZERO_L);
         if (rx_valid) begin
            if ((level_r != DEPTH_L) || pop_s) begin
               push_s = 1'b1;
            end else begin
               drop_s = 1'b1;
            end
         end else begin
            push_s = 1'b0;
            drop_s = 1'b0;
         end
      end
   end

   // Byte storage; contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wp_r] <= rx_data;
      end
   end

   // Pointers, occupancy and the popped-byte register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp_r      <= '0;
         rp_r      <= '0;
         level_r   <= ZERO_L;
         rd_data_r <= 8'h00;
      end else if (flush) begin
         wp_r    <= '0;
         rp_r    <= '0;
         level_r <= ZERO_L;
      end else begin
         if (push_s) begin
            wp_r <= wp_r + PTR_ONE_L;
         end
         if (pop_s) begin
            rd_data_r <= mem_r[rp_r];
            rp_r      <= rp_r + PTR_ONE_L;
         end
         case ({push_s, pop_s})
            2'b10:   level_r <= level_r + ONE_L;
            2'b01:   level_r <= level_r - ONE_L;
            default: level_r <= level_r;
         endcase
      end
   end

   // Sticky overrun; a drop in the same cycle as lsr_rd keeps the flag set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overrun_r <= 1'b0;
      end else if (drop_s) begin
         overrun_r <= 1'b1;
      end else if (lsr_rd) begin
         overrun_r <= 1'b0;
      end
   end

`ifdef UART_RX_TIMEOUT_EN
   localparam logic [15:0] TMO_LAST_L = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] tmo_cnt_r;
   logic        timeout_pend_r;

   // Idle counter: any FIFO activity restarts it, saturating once the timeout fires.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt_r      <= 16'd0;
         timeout_pend_r <= 1'b0;
      end else if (flush || push_s || pop_s) begin
         tmo_cnt_r      <= 16'd0;
         timeout_pend_r <= 1'b0;
      end else if (level_r == ZERO_L) begin
         tmo_cnt_r <= 16'd0;
      end else if (tmo_cnt_r == TMO_LAST_L) begin
         timeout_pend_r <= 1'b1;
      end else begin
         tmo_cnt_r <= tmo_cnt_r + 16'd1;
      end
   end

   assign timeout_pend_s = timeout_pend_r;
`else
   assign timeout_pend_s = 1'b0;
`endif

   assign rd_data    = rd_data_r;
   assign level      = level_r;
   assign data_ready = (level_r != ZERO_L);
   assign overrun    = overrun_r;
   assign irq        = (level_r >= TRIG_L) | timeout_pend_s;

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Self-checking bench for uart_rx_fifo_ctrl: vector table, hand sequences and randomized traffic vs a queue model.
module tb_uart_rx_fifo_ctrl;

   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int TRIG  = 8;
   localparam int TMO   = 20;
`ifdef UART_RX_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [7:0]    rx_data = 8'h00;
   logic          rx_valid = 1'b0;
   logic          rd_en = 1'b0;
   logic          flush = 1'b0;
   logic          lsr_rd = 1'b0;
   logic [7:0]    rd_data;
   logic          data_ready;
   logic [AW:0]   level;
   logic          overrun;
   logic          irq;

   always #5 clk = ~clk;

   uart_rx_fifo_ctrl #(
      .DEPTH(DEPTH), .TRIG_LEVEL(TRIG), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
      .rd_en(rd_en), .flush(flush), .lsr_rd(lsr_rd), .rd_data(rd_data),
      .data_ready(data_ready), .level(level), .overrun(overrun), .irq(irq)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: byte queue, last popped byte, sticky flag, idle-cycle count.
   logic [7:0] mq[$];
   logic [7:0] m_rd;
   bit         m_ovr;
   int         m_idle;

   function automatic bit m_irq();
      return (mq.size() >= TRIG) || (TMO_EN && mq.size() > 0 && m_idle >= TMO);
   endfunction

   task automatic model_reset();
      mq.delete();
      m_rd = 8'h00;
      m_ovr = 1'b0;
      m_idle = 0;
   endtask

   task automatic model_edge(input bit v, input logic [7:0] d, input bit r, input bit f, input bit l);
      bit act = 1'b0;
      bit set = 1'b0;
      if (f) begin
         mq.delete();
         act = 1'b1;
      end else begin
         if (r && mq.size() > 0) begin
            m_rd = mq.pop_front();
            act = 1'b1;
         end
         if (v) begin
            if (mq.size() < DEPTH) begin
               mq.push_back(d);
               act = 1'b1;
            end else begin
               set = 1'b1;
            end
         end
      end
      if (set) m_ovr = 1'b1;
      else if (l) m_ovr = 1'b0;
      if (act) m_idle = 0;
      else if (m_idle < TMO) m_idle = m_idle + 1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".level"}, 32'(level), 32'(mq.size()));
      chk({tag, ".data_ready"}, 32'(data_ready), 32'(mq.size() != 0));
      chk({tag, ".rd_data"}, 32'(rd_data), 32'(m_rd));
      chk({tag, ".overrun"}, 32'(overrun), 32'(m_ovr));
      chk({tag, ".irq"}, 32'(irq), 32'(m_irq()));
   endtask

   // One clock: drive at negedge, update model at posedge, sample 1 time unit later.
   task automatic step(input bit v, input logic [7:0] d, input bit r, input bit f, input bit l, input string tag);
      @(negedge clk);
      rx_valid = v; rx_data = d; rd_en = r; flush = f; lsr_rd = l;
      @(posedge clk);
      model_edge(v, d, r, f, l);
      #1;
      rx_valid = 1'b0; rd_en = 1'b0; flush = 1'b0; lsr_rd = 1'b0;
      check_model(tag);
   endtask

   typedef struct {
      bit         v;
      logic [7:0] d;
      bit         r;
      bit         f;
      bit         l;
      int         exp_level;
      logic [7:0] exp_rd;
      bit         exp_ovr;
      bit         exp_irq;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(bit v, logic [7:0] d, bit r, bit f, bit l,
                               int el, logic [7:0] er, bit eo, bit ei);
      vec_t x;
      x.v = v; x.d = d; x.r = r; x.f = f; x.l = l;
      x.exp_level = el; x.exp_rd = er; x.exp_ovr = eo; x.exp_irq = ei;
      return x;
   endfunction

   initial begin
      logic [7:0] rd_before;
      int rate_v;
      int rate_r;

      // Vector table; starts from an empty FIFO whose last popped byte is 8'hA5.
      for (int i = 0; i < 7; i++)
         tbl.push_back(mk(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0, i + 1, 8'hA5, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 8'h37, 1'b0, 1'b0, 1'b0, 8, 8'hA5, 1'b0, 1'b1));
      tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 7, 8'h30, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 8'h99, 1'b0, 1'b1, 1'b0, 0, 8'h30, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 8'h41, 1'b1, 1'b0, 1'b0, 1, 8'h30, 1'b0, 1'b0));
      tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 8'h41, 1'b0, 1'b0));
      tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 8'h41, 1'b0, 1'b0));

      // Reset, then mid-traffic reset with five bytes stored.
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 1'b0, "pre_rst");
      chk("pre_rst.level5", 32'(level), 32'd5);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("rst_async.level", 32'(level), 32'd0);
      chk("rst_async.data_ready", 32'(data_ready), 32'd0);
      chk("rst_async.rd_data", 32'(rd_data), 32'h00);
      chk("rst_async.overrun", 32'(overrun), 32'd0);
      chk("rst_async.irq", 32'(irq), 32'd0);
      @(posedge clk); #1;
      chk("rst_held.level", 32'(level), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, "post_rst_push");
      chk("post_rst.level", 32'(level), 32'd1);
      chk("post_rst.data_ready", 32'(data_ready), 32'd1);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "post_rst_pop");
      chk("post_rst.rd_data", 32'(rd_data), 32'hA5);
      chk("post_rst.level0", 32'(level), 32'd0);

      // Table-driven vectors.
      foreach (tbl[i]) begin
         step(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].f, tbl[i].l, "tbl");
         chk($sformatf("tbl[%0d].level", i), 32'(level), 32'(tbl[i].exp_level));
         chk($sformatf("tbl[%0d].rd_data", i), 32'(rd_data), 32'(tbl[i].exp_rd));
         chk($sformatf("tbl[%0d].overrun", i), 32'(overrun), 32'(tbl[i].exp_ovr));
         chk($sformatf("tbl[%0d].irq", i), 32'(irq), 32'(tbl[i].exp_irq));
      end

      // Ordering and pointer wrap.
      for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, "wrap_fill");
      chk("wrap.full", 32'(level), 32'd16);
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "wrap_pop1");
         chk("wrap.pop1", 32'(rd_data), 32'(i));
      end
      for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0, "wrap_push2");
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "wrap_pop2");
         chk("wrap.pop2", 32'(rd_data), 32'(8 + i));
      end

      // Overrun set/clear priority and full push+pop.
      for (int i = 0; i < 16; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0, "ovr_fill");
      step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, "ovr_drop");
      chk("ovr.level", 32'(level), 32'd16);
      chk("ovr.set", 32'(overrun), 32'd1);
      step(1'b1, 8'hEF, 1'b0, 1'b0, 1'b1, "ovr_set_wins");
      chk("ovr.set_wins", 32'(overrun), 32'd1);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "ovr_clear");
      chk("ovr.clear", 32'(overrun), 32'd0);
      step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0, "full_push_pop");
      chk("full_pp.level", 32'(level), 32'd16);
      chk("full_pp.rd_data", 32'(rd_data), 32'hC0);
      for (int i = 1; i < 16; i++) begin
         step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "ovr_drain");
         chk("ovr.drain", 32'(rd_data), 32'(8'hC0 + i));
      end
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "ovr_last");
      chk("ovr.last_is_new", 32'(rd_data), 32'h77);

      // Character timeout: irq rises exactly TMO clocks after the push, or never without the feature.
      rd_before = rd_data;
      step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, "tmo_push");
      for (int k = 1; k < TMO + 5; k++) begin
         step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "tmo_idle");
         chk($sformatf("tmo.irq_k%0d", k), 32'(irq), 32'(TMO_EN && (k >= TMO)));
      end
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "tmo_pop");
      chk("tmo.irq_clear", 32'(irq), 32'd0);
      chk("tmo.rd_data", 32'(rd_data), 32'h5A);
      chk("tmo.prev_rd", 32'(rd_before), 32'h77);

      // Randomized traffic with alternating busy and sparse phases.
      for (int blk = 0; blk < 10; blk++) begin
         rate_v = (blk % 2 == 0) ? 3 : 12;
         rate_r = (blk % 2 == 0) ? 3 : 40;
         for (int c = 0; c < 200; c++) begin
            step(($urandom % rate_v) == 0, 8'($urandom), ($urandom % rate_r) == 0,
                 ($urandom % 60) == 0, ($urandom % 10) == 0, "rand");
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo_ctrl.md
# uart_rx_fifo_ctrl

Receive-side controller between the 115200 8-N-1 UART receiver and the LPC register decoder. Captures each single-cycle `data_valid` byte pulse from the receiver into a small FIFO. Presents the bytes to the host through a pop handshake and keeps data-ready and sticky overrun status. Raises an interrupt on a fill threshold and, optionally, on a character timeout.

## Interface
- `DEPTH`, 16, FIFO entries; power of two, 2..256.
- `AW`, `$clog2(DEPTH)`, pointer width; do not override.
- `TRIG_LEVEL`, 8, `irq` asserts when `level >= TRIG_LEVEL`; legal range 1..DEPTH.
- `TIMEOUT_CYCLES`, 11440, idle clocks before a timeout interrupt (about 4 characters at 286 clk/bit); legal range 2..65535.

- `clk`  in  1  system clock (33 MHz LPC clock); all logic on its rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `rx_data`  in  8  byte from the receiver; valid only while `rx_valid` is high.
- `rx_valid`  in  1  one-cycle pulse per received byte.
- `rd_en`  in  1  host pop strobe, one cycle per byte.
- `flush`  in  1  synchronous FIFO clear.
- `lsr_rd`  in  1  host read of the line-status register; clears `overrun`.
- `rd_data`  out  8  registered popped byte.
- `data_ready`  out  1  FIFO non-empty (`level != 0`).
- `level`  out  AW+1  current occupancy, 0..DEPTH.
- `overrun`  out  1  sticky flag: a byte was dropped because the FIFO was full.
- `irq`  out  1  interrupt request, level-sensitive.

## Operation
- Storage is DEPTH×8 with write pointer `wp`, read pointer `rp` and an AW+1-bit `level` counter. Pointers wrap modulo DEPTH.
- **Push:** on `rx_valid`, if `level < DEPTH` or a pop happens in the same cycle, write `rx_data` at `wp`, increment `wp`, and increment `level` (unless a pop also occurs).
- **Push while full:** when `rx_valid` arrives with `level == DEPTH` and no pop, drop the byte, set `overrun`, and leave the contents untouched.
- **Pop:** on `rd_en` with `level != 0`, load `rd_data` with `mem[rp]`, increment `rp`, and decrement `level` (unless a push also occurs).
- **Pop while empty:** `rd_en` with `level == 0` is ignored; `rd_data` holds and no pointer moves.
- **Simultaneous push and pop:**
  - When non-empty, both take effect and `level` is unchanged.
  - When empty, only the push happens; there is no fall-through.
- **Flush:** `flush` sets `wp`, `rp` and `level` to 0.
  - A same-cycle push or pop is discarded.
  - `overrun` and `rd_data` are unaffected.
- **Overrun clearing:** `lsr_rd` clears `overrun`. If a set and `lsr_rd` land in the same cycle, the set wins.
- **Interrupt:** `irq = (level >= TRIG_LEVEL) | timeout_pend`, where `timeout_pend` is forced to 0 when the macro is absent.

## Timing
- **Reset values:** `rd_data = 8'h00`, `level = 0`, `data_ready = 0`, `overrun = 0`, `irq = 0`; pointers, timeout counter and `timeout_pend` are 0. Memory contents are not reset.
- **Push to flags:** `rx_valid` at edge N gives updated `level`, `data_ready` and threshold `irq` after edge N.
- **Pop latency:** `rd_en` at edge N gives `rd_data` valid after edge N (one cycle), with `level` and flags updated at the same edge.
- **Back-to-back:** `rd_en` on consecutive cycles returns consecutive bytes. Pushes arrive at most once per 2860 clocks, but any rate must be handled.
- **Registered outputs:** every output is a flop or a direct decode of `level`/flops; there is no combinational path from inputs to outputs.
- **Mid-operation reset:** asserting `rst_n` low mid-operation clears state immediately, without waiting for `clk`.

## Configuration
- Macro `UART_RX_TIMEOUT_EN` enables the character-timeout logic.
  - A 16-bit counter clears on push, pop, flush, or `level == 0`, and otherwise increments.
  - On reaching `TIMEOUT_CYCLES-1` it sets `timeout_pend` and saturates.
  - `timeout_pend` clears on any pop, flush, or push.
- Without the macro, no counter is synthesized, `timeout_pend` is constant 0, and `irq` is threshold-only.

## Test plan
- **Reset:** hold `rst_n` low mid-traffic with `level = 5` -> all outputs at reset values while low; after release, push `8'hA5` -> `level = 1`, `data_ready = 1`; `rd_en` -> `rd_data = 8'hA5`, `level = 0`.
- **Order and wrap:** push 0x00..0x0F (DEPTH = 16), pop 8, push 0x10..0x17, pop 16 -> bytes return in order 0x08..0x17, confirming `wp`/`rp` wrap.
- **Overrun:** fill 16, push `8'hEE` -> `level = 16`, `overrun = 1`, `8'hEE` never read back. Pulse `lsr_rd` together with another full push -> `overrun` stays 1; a lone `lsr_rd` -> 0.
- **Simultaneous events:**
  - Full FIFO, push and pop together -> `level = 16`, new byte stored.
  - Empty FIFO, push and pop together -> `level = 1`, `rd_data` unchanged.
  - Push with `flush` -> `level = 0`.
- **Threshold:** push 7 -> `irq = 0`; push 8th -> `irq = 1` the cycle after; pop one -> `irq = 0`.
- **Timeout (`UART_RX_TIMEOUT_EN` defined, `TIMEOUT_CYCLES = 20`):** push 1 byte, idle -> `irq` rises exactly 20 clocks after the push and clears the cycle after `rd_en`. With the macro undefined, the same stimulus leaves `irq = 0` throughout.
